// File: rtl/lstm_gate_scheduler.sv
// Time-shares one W*x + U*h datapath across the i/f/o/g gates of an LSTM cell, adds per-gate bias.
// Optional macro LSTM_SAT_EN: bias add saturates instead of wrapping.
module lstm_gate_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_h,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_gate,
  input  logic [1:0]                   cfg_sel,
  input  logic signed [DATA_WIDTH-1:0] cfg_data,
  output logic                         cfg_err,
  output logic signed [DATA_WIDTH-1:0] dp_w,
  output logic signed [DATA_WIDTH-1:0] dp_x,
  output logic signed [DATA_WIDTH-1:0] dp_u,
  output logic signed [DATA_WIDTH-1:0] dp_h,
  input  logic signed [DATA_WIDTH-1:0] dp_result,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_f,
  output logic signed [DATA_WIDTH-1:0] out_o,
  output logic signed [DATA_WIDTH-1:0] out_g,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam logic signed [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1) << FRACT_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic [1:0] gcnt;
  logic signed [DATA_WIDTH-1:0] w_reg [4];
  logic signed [DATA_WIDTH-1:0] u_reg [4];
  logic signed [DATA_WIDTH-1:0] b_reg [4];
  logic signed [DATA_WIDTH-1:0] res   [4];
  logic signed [DATA_WIDTH-1:0] x_lat, h_lat;
  logic cfg_bad, cfg_ok;

  // One extra bit keeps the true sum; the top two bits disagree exactly on overflow.
  function automatic logic signed [DATA_WIDTH-1:0] bias_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
`ifdef LSTM_SAT_EN
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      return sum[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
`endif
    return sum[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (gcnt == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign cfg_bad   = cfg_we && ((state == RUN) || (cfg_sel == 2'd3));
  assign cfg_ok    = cfg_we && !cfg_bad;

  always_comb begin
    dp_w = '0;
    dp_u = '0;
    dp_x = '0;
    dp_h = '0;
    if (state == RUN) begin
      dp_w = w_reg[gcnt];
      dp_u = u_reg[gcnt];
      dp_x = x_lat;
      dp_h = h_lat;
    end
  end

  // Sample latch, gate counter and per-gate result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt  <= '0;
      x_lat <= '0;
      h_lat <= '0;
      for (int k = 0; k < 4; k++) res[k] <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        x_lat <= in_x;
        h_lat <= in_h;
        gcnt  <= '0;
      end else if (state == RUN) begin
        res[gcnt] <= bias_add(dp_result, b_reg[gcnt]);
        gcnt      <= gcnt + 2'd1;
      end
    end
  end

  // Register file; writes from RUN are dropped so an in-flight sample sees stable weights.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        w_reg[k] <= ONE;
        u_reg[k] <= ONE;
        b_reg[k] <= '0;
      end
    end else begin
      cfg_err <= cfg_bad;
      if (cfg_ok) begin
        case (cfg_sel)
          2'd0:    w_reg[cfg_gate] <= cfg_data;
          2'd1:    u_reg[cfg_gate] <= cfg_data;
          default: b_reg[cfg_gate] <= cfg_data;
        endcase
      end
    end
  end

  assign out_i = res[0];
  assign out_f = res[1];
  assign out_o = res[2];
  assign out_g = res[3];

endmodule

// File: doc/lstm_gate_scheduler.md
# lstm_gate_scheduler

Sequencer that time-shares one weighted-sum datapath (W·x + U·h, Q8.8) across the four gates of an LSTM cell (input i, forget f, output o, candidate g). It holds per-gate W/U/b in a small register file, accepts one (x, h) sample per valid/ready handshake, and steps the shared datapath through the gates. It adds each gate's bias and presents all four pre-activations together. It sits between the cell input staging and the sigmoid/tanh activation stage.

## Interface
- DATA_WIDTH, 16, operand/result width, signed two's complement
- FRACT_WIDTH, 8, fractional bits (Q8.8)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  x/h sample offered
- in_ready  out  1  block can accept a sample
- in_x, in_h  in  16 each  input sample, previous hidden state
- cfg_we  in  1  weight register write strobe
- cfg_gate  in  2  gate index: 0 = i, 1 = f, 2 = o, 3 = g
- cfg_sel  in  2  0 = W, 1 = U, 2 = b, 3 = reserved
- cfg_data  in  16  write data
- cfg_err  out  1  one-cycle pulse: write rejected
- dp_w, dp_x, dp_u, dp_h  out  16 each  operands to the shared datapath
- dp_result  in  16  combinational W·x + U·h from the datapath
- out_i, out_f, out_o, out_g  out  16 each  biased pre-activations
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts results

## Operation
- Register file: 4 gates × {W, U, b}.
  - Reset values: W = U = 0x0100 (1.0), b = 0x0000.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid: latch in_x/in_h, clear gate counter gcnt, go to RUN.
- RUN
  - gcnt selects the gate, 0→3.
  - dp_w/dp_u come from the register file for gate gcnt; dp_x/dp_h come from the latched sample.
  - At the clock edge: result[gcnt] ← dp_result + b[gcnt], then gcnt increments.
  - After gcnt = 3 is captured, go to DONE. gcnt is 2 bits and wraps to 0.
- DONE
  - out_valid = 1; out_* hold result registers.
  - On out_ready: go to IDLE. Samples are not accepted in the same cycle (in_ready = 0 in DONE).
- dp_* outputs are 0 outside RUN.
- Bias add: 17-bit signed sum, then saturated or wrapped to 16 bits (see Configuration).
- Config writes:
  - Accepted in IDLE and DONE; take effect on the next edge.
  - In RUN, writes are ignored and cfg_err pulses the following cycle.
  - cfg_sel = 3 is ignored and cfg_err pulses.
  - A write in DONE does not alter out_*, which are already captured.
- Reset mid-operation: FSM → IDLE, gcnt = 0, result registers = 0, weights back to reset values, latched sample discarded.
- Reset values of outputs: in_ready = 1, out_valid = 0, out_* = 0, dp_* = 0, cfg_err = 0.

## Timing
- Handshake edge = cycle 0. RUN spans cycles 1–4 (one gate per cycle). out_valid rises in cycle 5.
- Latency is 5 cycles to out_valid.
- Minimum period is 6 cycles per sample: 1 IDLE + 4 RUN + ≥1 DONE.
- out_valid and out_* stay stable until the cycle in which out_ready = 1 (included). out_valid deasserts the next cycle.
- in_ready is a function of state only, with no combinational path from in_valid or out_ready.
- dp_result is sampled in the same cycle the operands are presented. The datapath must be single-cycle combinational.
- A simultaneous cfg_we and in_valid in IDLE is legal: the sample is accepted and the write commits. The RUN gates use the new value.

## Configuration
- LSTM_SAT_EN defined:
  - Bias add saturates.
  - Sum > 0x7FFF → 0x7FFF; sum < 0x8000 (as signed) → 0x8000.
- Undefined: bias add wraps modulo 2^16 (low 16 bits of the sum).

## Test plan
- After reset with no config writes, x = 0x0200, h = 0x0100, handshake. Expect: dp_result = 0x0300 each RUN cycle; out_i = out_f = out_o = out_g = 0x0300; out_valid at cycle 5.
- Write b[f] = 0x0080 and W[o] = 0x0200, then run x = h = 0x0100. Expect: out_f = 0x0280, out_o = 0x0300, others = 0x0200; dp_w = 0x0200 only in RUN cycle 3.
- b[i] = 0x7F00 with dp_result = 0x0200. Expect: out_i = 0x7FFF with LSTM_SAT_EN; out_i = 0x8100 without it.
- cfg_we during RUN cycle 2. Expect: cfg_err pulse in cycle 3, register file unchanged, results unaffected; a write with cfg_sel = 3 in IDLE also pulses cfg_err.
- Hold out_ready = 0 for 10 cycles after DONE. Expect: out_valid and out_* held, in_ready = 0, in_valid ignored; with out_ready = 1, IDLE next cycle and a new sample accepted the following cycle.
- Assert rst in RUN cycle 2. Expect: outputs at reset values immediately, W/U/b restored, the next sample computes from defaults.
